// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: inter-stage pipeline register for the RV32E core.
// Holds one payload (two when PIPELINE_SKID_BUF_EN is defined) behind a
// valid/ready handshake, supports flush, drives BUBBLE whenever the output
// is not valid, and counts back-pressure cycles with a saturating counter.
// Optional feature macro: PIPELINE_SKID_BUF_EN (adds a skid entry so that
// in_ready has no combinational path from out_ready).

module pipeline_stage_reg #(
  parameter int                     PAYLOAD_W   = 96,
  parameter logic [PAYLOAD_W-1:0]   BUBBLE      = {{(PAYLOAD_W-32){1'b0}}, 32'h13},
  parameter int                     STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PAYLOAD_W-1:0]   out_payload,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

`ifdef PIPELINE_SKID_BUF_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1
  } state_t;
`endif

  state_t                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   mainPayload_q, mainPayload_d;
  logic [STALL_CNT_W-1:0] stallCycles_q, stallCycles_d;
  logic                   inAccept;
  logic                   outAccept;

`ifdef PIPELINE_SKID_BUF_EN
  logic [PAYLOAD_W-1:0]   skidPayload_q, skidPayload_d;
`endif

  // The main entry register itself holds BUBBLE whenever it is empty, so the
  // output payload comes straight from a flop.
  assign out_valid    = (state_q != EMPTY);
  assign out_payload  = mainPayload_q;
  assign stall_cycles = stallCycles_q;

`ifdef PIPELINE_SKID_BUF_EN
  // Only the registered state decides readiness; flush still blocks input.
  assign in_ready = (state_q != SKID) && !flush;
`else
  // Ready when empty or when the held payload is leaving this cycle.
  assign in_ready = (!out_valid || out_ready) && !flush;
`endif

  assign inAccept  = in_valid && in_ready;
  assign outAccept = out_valid && out_ready;

  // Next-state and next-payload selection; flush overrides every transfer.
  always_comb begin
    state_d       = state_q;
    mainPayload_d = mainPayload_q;
`ifdef PIPELINE_SKID_BUF_EN
    skidPayload_d = skidPayload_q;
`endif
    if (flush) begin
      state_d       = EMPTY;
      mainPayload_d = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (inAccept) begin
            state_d       = FULL;
            mainPayload_d = in_payload;
          end
        end
        FULL: begin
          if (outAccept && inAccept) begin
            mainPayload_d = in_payload;
          end else if (outAccept) begin
            state_d       = EMPTY;
            mainPayload_d = BUBBLE;
          end
`ifdef PIPELINE_SKID_BUF_EN
          else if (inAccept) begin
            state_d       = SKID;
            skidPayload_d = in_payload;
          end
`endif
        end
`ifdef PIPELINE_SKID_BUF_EN
        SKID: begin
          if (outAccept) begin
            state_d       = FULL;
            mainPayload_d = skidPayload_q;
          end
        end
`endif
        default: begin
          state_d       = EMPTY;
          mainPayload_d = BUBBLE;
        end
      endcase
    end
  end

  // Stall counter saturates at all-ones and ignores flush.
  always_comb begin
    stallCycles_d = stallCycles_q;
    if (out_valid && !out_ready && (stallCycles_q != {STALL_CNT_W{1'b1}})) begin
      stallCycles_d = stallCycles_q + STALL_CNT_W'(1);
    end
  end

  // State, payload and counter registers; reset drops all held data at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      mainPayload_q <= BUBBLE;
      stallCycles_q <= '0;
`ifdef PIPELINE_SKID_BUF_EN
      skidPayload_q <= BUBBLE;
`endif
    end else begin
      state_q       <= state_d;
      mainPayload_q <= mainPayload_d;
      stallCycles_q <= stallCycles_d;
`ifdef PIPELINE_SKID_BUF_EN
      skidPayload_q <= skidPayload_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb_pipeline_stage_reg: directed scenarios plus randomized traffic for
// pipeline_stage_reg, checked every cycle against a queue-based model.
// A second instance with a 4-bit counter exercises stall-count saturation.
`timescale 1ns/1ps

module tb_pipeline_stage_reg;

  localparam int PW = 96;
  localparam logic [PW-1:0] BUB = {{(PW-32){1'b0}}, 32'h13};

`ifdef PIPELINE_SKID_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_payload = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          inReady, outValid;
  logic [PW-1:0] outPayload;
  logic [15:0]   stallMain;
  logic          satInReady, satOutValid;
  logic [PW-1:0] satOutPayload;
  logic [3:0]    stallSat;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] modelQ[$];
  int            modelStall = 0;

  localparam logic [PW-1:0] PA = 96'h0000_1000_0000_1004_00A0_0093;
  localparam logic [PW-1:0] PB = 96'h0000_1004_0000_1008_00B0_0113;
  localparam logic [PW-1:0] PC = 96'h0000_1008_0000_100C_00C0_0193;

  pipeline_stage_reg #(.PAYLOAD_W(PW), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady),
    .in_payload(in_payload), .flush(flush), .out_valid(outValid),
    .out_ready(out_ready), .out_payload(outPayload), .stall_cycles(stallMain)
  );

  pipeline_stage_reg #(.PAYLOAD_W(PW), .STALL_CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(satInReady),
    .in_payload(in_payload), .flush(flush), .out_valid(satOutValid),
    .out_ready(out_ready), .out_payload(satOutPayload), .stall_cycles(stallSat)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Readiness as the handshake rules define it: capacity left, or the head
  // leaving this cycle when there is no skid entry; never during flush.
  function automatic logic modelInReady();
    if (flush) return 1'b0;
    if (CAP == 2) return (modelQ.size() < 2);
    return (modelQ.size() == 0) || out_ready;
  endfunction

  // Reference model: a FIFO of held payloads plus an unbounded stall count.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelQ.delete();
      modelStall = 0;
    end else begin
      logic inAcc, outAcc;
      inAcc  = in_valid && modelInReady();
      outAcc = (modelQ.size() > 0) && out_ready;
      if ((modelQ.size() > 0) && !out_ready) modelStall++;
      if (flush) begin
        modelQ.delete();
      end else begin
        if (outAcc) void'(modelQ.pop_front());
        if (inAcc) modelQ.push_back(in_payload);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  task automatic compareModel();
    logic [PW-1:0] expPayload;
    logic [15:0]   expMain;
    logic [3:0]    expSat;
    expPayload = (modelQ.size() > 0) ? modelQ[0] : BUB;
    expMain    = (modelStall > 65535) ? 16'hFFFF : 16'(modelStall);
    expSat     = (modelStall > 15) ? 4'hF : 4'(modelStall);
    checkOutput("out_valid", PW'(outValid), PW'(modelQ.size() > 0));
    checkOutput("out_payload", outPayload, expPayload);
    checkOutput("in_ready", PW'(inReady), PW'(modelInReady()));
    checkOutput("stall_cycles", PW'(stallMain), PW'(expMain));
    checkOutput("sat_stall_cycles", PW'(stallSat), PW'(expSat));
    checkOutput("sat_out_payload", satOutPayload, expPayload);
  endtask

  // Drive one cycle of inputs after the falling edge, then compare.
  task automatic applyStimulus(input logic v, input logic [PW-1:0] p, input logic f, input logic r);
    @(negedge clk);
    in_valid   = v;
    in_payload = p;
    flush      = f;
    out_ready  = r;
    #2;
    compareModel();
  endtask

  initial begin
    logic [PW-1:0] rp;
    #12;
    rst = 1'b0;

    // Streaming A, B, C with the downstream always ready.
    applyStimulus(1'b1, PA, 1'b0, 1'b1);
    applyStimulus(1'b1, PB, 1'b0, 1'b1);
    checkOutput("stream_a", outPayload, PA);
    applyStimulus(1'b1, PC, 1'b0, 1'b1);
    checkOutput("stream_b", outPayload, PB);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("stream_c", outPayload, PC);
    checkOutput("stream_valid", PW'(outValid), PW'(1'b1));
    checkOutput("stream_stall", PW'(stallMain), PW'(16'd0));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("stream_empty", outPayload, BUB);

    // Back-pressure: A held for five stalled edges while B is offered.
    applyStimulus(1'b1, PA, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, PB, 1'b0, 1'b0);
      checkOutput("bp_hold_a", outPayload, PA);
`ifdef PIPELINE_SKID_BUF_EN
      checkOutput("bp_in_ready", PW'(inReady), PW'(i == 0));
`else
      checkOutput("bp_in_ready", PW'(inReady), PW'(1'b0));
`endif
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("bp_stall5", PW'(stallMain), PW'(16'd5));
    checkOutput("bp_release_a", outPayload, PA);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
`ifdef PIPELINE_SKID_BUF_EN
    checkOutput("bp_then_b", outPayload, PB);
`else
    checkOutput("bp_then_empty", outPayload, BUB);
`endif
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("bp_drained", PW'(outValid), PW'(1'b0));

    // Flush with A held while B is offered.
    applyStimulus(1'b1, PA, 1'b0, 1'b1);
    applyStimulus(1'b1, PB, 1'b1, 1'b1);
    checkOutput("flush_in_ready", PW'(inReady), PW'(1'b0));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("flush_valid", PW'(outValid), PW'(1'b0));
    checkOutput("flush_bubble", outPayload, BUB);
    checkOutput("flush_stall", PW'(stallMain), PW'(16'd5));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("flush_b_dropped", PW'(outValid), PW'(1'b0));

    // Simultaneous consume of A and accept of B.
    applyStimulus(1'b1, PA, 1'b0, 1'b0);
    applyStimulus(1'b1, PB, 1'b0, 1'b1);
    checkOutput("simul_a", outPayload, PA);
    checkOutput("simul_in_ready", PW'(inReady), PW'(1'b1));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("simul_b", outPayload, PB);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("simul_once", PW'(outValid), PW'(1'b0));

    // Asynchronous reset mid-cycle while A is held.
    applyStimulus(1'b1, PA, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("rst_pre_valid", PW'(outValid), PW'(1'b1));
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_valid", PW'(outValid), PW'(1'b0));
    checkOutput("rst_low_word", PW'(outPayload[31:0]), PW'(32'h13));
    checkOutput("rst_in_ready", PW'(inReady), PW'(1'b1));
    checkOutput("rst_stall", PW'(stallMain), PW'(16'd0));
    rst = 1'b0;

    // Saturation of the 4-bit counter over twenty stalled edges.
    applyStimulus(1'b1, PA, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      if (i == 16) checkOutput("sat_at_15", PW'(stallSat), PW'(4'hF));
      if (i == 17) checkOutput("sat_no_wrap", PW'(stallSat), PW'(4'hF));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("sat_final", PW'(stallSat), PW'(4'hF));
    checkOutput("sat_main20", PW'(stallMain), PW'(16'd20));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic with occasional flush and mid-cycle reset.
    for (int n = 0; n < 3000; n++) begin
      rp = {$urandom, $urandom, $urandom};
      applyStimulus($urandom_range(0, 3) != 0, rp, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
